fifo_uart_tx: RTL

- Consumer-side drain engine for the team's 8-bit synchronous FIFO.
- Pops bytes through the FIFO read port (read strobe, empty flag, registered data) and serialises each byte as an asynchronous UART frame on a single line.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Sits between a FIFO instance and the device TX pin.

---
 rtl/fifo_uart_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from an 8-bit synchronous FIFO and serialises
// each one as a UART frame (start, 8 data bits LSB first, optional even
// parity, stop) on a single idle-high line.
//
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   defined   -> even-parity bit inserted between data and stop (11-bit frame)
//   undefined -> no parity logic, 10-bit frame
//
// Ports:
//   clk         system clock, rising edge
//   rstn        synchronous active-low reset
//   enable      permits starting new frames (sampled only while idle)
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after a pop
//   fifo_rd     FIFO read strobe, one-cycle registered pulse per byte
//   tx          serial line, idle high
//   busy        high whenever the engine is not idle
//   frame_done  one-cycle pulse when a stop bit completes
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd6;
`endif

  logic [2:0]        state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              tx_n, fifo_rd_n, busy_n, frame_done_n;
  logic              baud_end_c;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity, parity_n;
`endif

  assign baud_end_c = (baud == BAUD_LAST);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      tx         <= tx_n;
      fifo_rd    <= fifo_rd_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
`ifdef FIFO_UART_TX_PARITY_EN
      parity     <= parity_n;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    baud_n       = baud;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    tx_n         = tx;
    fifo_rd_n    = 1'b0;
    busy_n       = busy;
    frame_done_n = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_n     = parity;
`endif

    // Baud counter runs in every serial state and wraps on the bit boundary
    if (state == S_START || state == S_DATA || state == S_STOP
`ifdef FIFO_UART_TX_PARITY_EN
        || state == S_PARITY
`endif
       ) begin
      baud_n = baud_end_c ? '0 : baud + 1'b1;
    end

    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (enable && !fifo_empty) begin
          fifo_rd_n = 1'b1;
          busy_n    = 1'b1;
          state_n   = S_FETCH;
        end
      end
      // Pop in flight; the FIFO presents the byte at the end of this cycle
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        shift_n   = fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_n  = ^fifo_dout;
`endif
        tx_n      = 1'b0;
        baud_n    = '0;
        bit_cnt_n = '0;
        state_n   = S_START;
      end
      S_START: begin
        if (baud_end_c) begin
          tx_n    = shift[0];
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          shift_n = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_n    = parity;
            state_n = S_PARITY;
`else
            tx_n    = 1'b1;
            state_n = S_STOP;
`endif
          end else begin
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end_c) begin
          tx_n    = 1'b1;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_end_c) begin
          frame_done_n = 1'b1;
          busy_n       = 1'b0;
          state_n      = S_IDLE;
        end
      end
      default: begin
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
